// File: rtl/regfile_pkg.sv
// Shared types and constants for the two-write, two-read register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  // Entry 0 is hardwired to zero: writes are dropped and reads return 0.
  localparam int ZERO_ADDR = 0;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, writing zero, then
// asserts ready. The pointer carries one extra bit so the terminal compare
// never aliases with a wrapped address.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  rf_state_t       state, state_nxt;
  logic [ADDR_W:0] clr_ptr, clr_ptr_nxt;

  // State and sweep pointer registers; reset restarts the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state logic: one entry cleared per cycle, leave CLEAR on the last one.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    clr_addr    = clr_ptr[ADDR_W-1:0];
    ready       = 1'b0;
    case (state)
      CLEAR: begin
        clr_we      = 1'b1;
        clr_ptr_nxt = clr_ptr + ONE;
        if (clr_ptr == LAST) state_nxt = READY;
      end
      READY: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/regfile_2w2r.sv
// Register file with two write ports (port 1 wins on collision), two
// combinational read ports and entry 0 hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle write data
// to a matching read port; without it reads see stored contents only.
module regfile_2w2r
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wen0, wen1;

  regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wen0 = ready && we0 && (wa0 != ZA);
  assign wen1 = ready && we1 && (wa1 != ZA);

  // Read mux: zero for entry 0 and during the sweep; optional write forwarding.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              rdy,
    input logic              e0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              e1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1
  );
    logic [DATA_W-1:0] r;
    r = stored;
`ifdef REGFILE_BYPASS_EN
    if (e1 && (a1 == ra))      r = d1;
    else if (e0 && (a0 == ra)) r = d0;
`else
    if (e0 || e1 || (a0 != a1) || (d0 != d1)) r = stored;
`endif
    if (!rdy || (ra == ZA)) r = '0;
    return r;
  endfunction

  // Storage update: the sweep zeroes entries; port 1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wen0) mem[wa0] <= wd0;
      if (wen1) mem[wa1] <= wd1;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd0 = rd_sel(ra0, mem[ra0], ready, wen0, wa0, wd0, wen1, wa1, wd1);
    rd1 = rd_sel(ra1, mem[ra1], ready, wen0, wa0, wd0, wen1, wa1, wd1);
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed self-checking bench for regfile_2w2r.
module tb_regfile_2w2r;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ra0, ra1, wa0, wa1;
  logic [DATA_W-1:0] rd0, rd1, wd0, wd1;
  logic              we0, we1, ready;

  int tests = 0;
  int fails = 0;
  int cnt;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_2w2r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  initial begin
    rst = 1'b1; ra0 = 5'd7; ra1 = 5'd0;
    idle();
    tick();
    // Reset state
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    rst = 1'b0;
    // Writes during the sweep must be ignored
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra0 = 5'd5; ra1 = 5'd5;
    for (int i = 1; i < 32; i++) begin
      tick();
      chk("sweep_ready_low", {31'b0, ready}, 32'd0);
      chk("sweep_rd0", rd0, 32'd0);
    end
    tick();
    chk("sweep_ready_high", {31'b0, ready}, 32'd1);
    idle();
    #1;
    chk("clear_write_ignored", rd0, 32'd0);

    // Write to entry 0 is discarded
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h12345678;
    tick(); idle(); ra0 = 5'd0; ra1 = 5'd0; #1;
    chk("zero_rd0", rd0, 32'd0);
    chk("zero_rd1", rd1, 32'd0);

    // Write 7 through port 1, read on port 1
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hA5A5A5A5; ra1 = 5'd7; #1;
    chk("wr7_same_cycle", rd1, BYP ? 32'hA5A5A5A5 : 32'd0);
    tick(); idle(); #1;
    chk("wr7_next_cycle", rd1, 32'hA5A5A5A5);

    // Collision on address 3: port 1 wins
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22222222;
    tick(); idle(); ra0 = 5'd3; #1;
    chk("collision", rd0, 32'h22222222);

    // Independent writes on both ports
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44444444;
    we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h66666666;
    tick(); idle(); ra0 = 5'd4; ra1 = 5'd6; #1;
    chk("dual_wr_rd0", rd0, 32'h44444444);
    chk("dual_wr_rd1", rd1, 32'h66666666);
    ra0 = 5'd3; ra1 = 5'd7; #1;
    chk("hold3", rd0, 32'h22222222);
    chk("hold7", rd1, 32'hA5A5A5A5);

    // Same-cycle read of a location being written
    ra0 = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFEF00D; #1;
    chk("bypass_rd0", rd0, BYP ? 32'hCAFEF00D : 32'd0);
    tick(); idle(); #1;
    chk("wr9", rd0, 32'hCAFEF00D);
    ra1 = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0BADF00D;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h600DF00D; #1;
    chk("bypass_both_rd1", rd1, BYP ? 32'h600DF00D : 32'hCAFEF00D);
    tick(); idle(); #1;
    chk("wr9_collision", rd1, 32'h600DF00D);

    // Reset from READY drops ready on the sampling edge
    rst = 1'b1; ra0 = 5'd7;
    tick();
    chk("rst_ready_falls", {31'b0, ready}, 32'd0);
    chk("rst_rd_gated", rd0, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    // Reset mid-sweep restarts it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("resweep_cycles", cnt, 32'd32);
    ra0 = 5'd7; ra1 = 5'd3; #1;
    chk("resweep_rd7", rd0, 32'd0);
    chk("resweep_rd3", rd1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
